// File: rtl/rf_dbg_pkg.sv
// Shared definitions for the register-file debug dump path.
// Holds the dump FSM state encoding, the default register-file geometry
// that the core's register file and controller also use, and the start/end
// indices of a dump for the default geometry.
package rf_dbg_pkg;

  // Default register-file geometry, shared with the register file and controller.
  localparam int REG_ADDR_W   = 5;
  localparam int REG_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

  // First and last dumped index for the default geometry with x0 included.
  localparam int FIRST = 0;
  localparam int LAST  = DEF_NUM_REGS - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

  // x0 is hardwired to zero, so a dump may start at index 1 instead.
  function automatic int first_index(input int skip_x0);
    return (skip_x0 != 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Sequential register-file dump reader.
// Walks the register file one index at a time through the core's shared read
// port. Each word is requested with a req/gnt handshake and then streamed out
// over valid/ready, so the core keeps using the port between words.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, abort        begin a dump (IDLE only), synchronous abort (any state)
//   busy, done          activity flag, one-cycle completion pulse
//   rf_req, rf_gnt      read-port request and grant from the core controller
//   rf_addr, rf_rdata   read address to A1, combinational data from RD1
//   out_valid/ready     output handshake
//   out_idx, out_data   register index and value of the current word
//   out_last            marks the final word of a dump
module regfile_dump_reader
  import rf_dbg_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W,
  parameter int SKIP_X0  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rf_req,
  input  logic              rf_gnt,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  // ADDR_W must cover NUM_REGS, so LAST_IDX fits and idx+1 never wraps.
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(first_index(SKIP_X0));
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state;
  dump_state_t       state_next;
  logic [ADDR_W-1:0] idx;
  logic              at_last;

  assign at_last = (idx == LAST_IDX);

  // State register; abort overrides every transition, including start in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the state-decoded outputs.
  // rf_addr is forced to zero outside REQ so the controller's A1 mux sees a
  // quiet value whenever the reader does not own the port.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    rf_req     = 1'b0;
    rf_addr    = '0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = REQ;
        end
      end
      REQ: begin
        rf_req  = 1'b1;
        rf_addr = idx;
        if (rf_gnt) begin
          state_next = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = at_last ? DONE : REQ;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Index counter and captured output word.
  // The word is captured on the grant edge and held untouched through SEND,
  // which keeps out_idx/out_data/out_last stable under backpressure without a
  // separate skid register. Abort clears everything back to reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      out_idx  <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (abort) begin
      idx      <= '0;
      out_idx  <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx <= FIRST_IDX;
          end
        end
        REQ: begin
          if (rf_gnt) begin
            out_idx  <= idx;
            out_data <= rf_rdata;
            out_last <= at_last;
          end
        end
        SEND: begin
          if (out_ready && !at_last) begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed self-checking bench for regfile_dump_reader.
// A behavioural register file drives rf_rdata from rf_addr. One instance uses
// the default geometry, a second one skips x0.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_b, abort;
  logic        rf_gnt, out_ready;

  logic        busy, done, rf_req, out_valid, out_last;
  logic [4:0]  rf_addr, out_idx;
  logic [31:0] rf_rdata, out_data;

  logic        busy_b, done_b, rf_req_b, out_valid_b, out_last_b;
  logic [4:0]  rf_addr_b, out_idx_b;
  logic [31:0] rf_rdata_b, out_data_b;

  logic [31:0] regs [32];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rf_rdata   = regs[rf_addr];
  assign rf_rdata_b = regs[rf_addr_b];

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .rf_req(rf_req), .rf_gnt(rf_gnt),
    .rf_addr(rf_addr), .rf_rdata(rf_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
    .out_last(out_last)
  );

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1)) dut_skip (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
    .busy(busy_b), .done(done_b), .rf_req(rf_req_b), .rf_gnt(rf_gnt),
    .rf_addr(rf_addr_b), .rf_rdata(rf_rdata_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_idx(out_idx_b), .out_data(out_data_b),
    .out_last(out_last_b)
  );

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic load_regs();
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + 32'(i);
  endtask

  // Runs one full dump starting from a negedge. With stalls set it also holds
  // off the grant at idx 3, applies backpressure at idx 7 and lets the core
  // overwrite x20 while word 5 is on the output.
  task automatic run_dump(input bit use_b, input int first, input int exp_done,
                          input bit stalls);
    int next_idx = first;
    int words = 0;
    int done_cyc = -1;
    int gnt_stall = 0;
    int rdy_stall = 0;
    logic v, rq, dn, ol;
    logic [4:0] ad, oi;
    logic [31:0] od, exp_data;
    rf_gnt = 1'b1;
    out_ready = 1'b1;
    if (use_b) start_b = 1'b1; else start = 1'b1;
    for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      start_b = 1'b0;
      v  = use_b ? out_valid_b : out_valid;
      rq = use_b ? rf_req_b    : rf_req;
      dn = use_b ? done_b      : done;
      ol = use_b ? out_last_b  : out_last;
      ad = use_b ? rf_addr_b   : rf_addr;
      oi = use_b ? out_idx_b   : out_idx;
      od = use_b ? out_data_b  : out_data;
      if (dn) done_cyc = cyc;
      if (stalls) begin
        rf_gnt = 1'b1;
        out_ready = 1'b1;
        if (rq && ad == 5'd3 && gnt_stall < 5) begin
          rf_gnt = 1'b0;
          gnt_stall++;
          check_output("stall_rf_req", 32'(rq), 32'd1);
          check_output("stall_rf_addr", 32'(ad), 32'd3);
          check_output("stall_no_valid", 32'(v), 32'd0);
        end
        if (v && oi == 5'd7 && rdy_stall < 4) begin
          out_ready = 1'b0;
          rdy_stall++;
          check_output("bp_out_idx", 32'(oi), 32'd7);
          check_output("bp_out_data", od, 32'h107);
          check_output("bp_rf_req", 32'(rq), 32'd0);
        end
        if (v && oi == 5'd5) regs[20] = 32'hDEADBEEF;
      end
      if (v && out_ready) begin
        exp_data = (stalls && next_idx == 20) ? 32'hDEADBEEF : 32'h100 + 32'(next_idx);
        check_output("word_idx", 32'(oi), 32'(next_idx));
        check_output("word_data", od, exp_data);
        check_output("word_last", 32'(ol), (next_idx == 31) ? 32'd1 : 32'd0);
        next_idx++;
        words++;
      end
    end
    rf_gnt = 1'b1;
    out_ready = 1'b1;
    check_output("done_cycle", 32'(done_cyc), 32'(exp_done));
    check_output("word_count", 32'(words), 32'(32 - first));
    if (stalls) begin
      check_output("gnt_stall_cycles", 32'(gnt_stall), 32'd5);
      check_output("rdy_stall_cycles", 32'(rdy_stall), 32'd4);
    end
    @(negedge clk);
    check_output("done_one_cycle", 32'(use_b ? done_b : done), 32'd0);
    check_output("busy_after_done", 32'(use_b ? busy_b : busy), 32'd0);
  endtask

  task automatic apply_stimulus();
    bit found;
    bit seen_done;
    // Reset state.
    rst_n = 1'b0;
    start = 1'b0; start_b = 1'b0; abort = 1'b0;
    rf_gnt = 1'b1; out_ready = 1'b1;
    load_regs();
    #12;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_rf_req", 32'(rf_req), 32'd0);
    check_output("rst_rf_addr", 32'(rf_addr), 32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_idx", 32'(out_idx), 32'd0);
    check_output("rst_out_data", out_data, 32'd0);
    check_output("rst_out_last", 32'(out_last), 32'd0);
    check_output("rst_busy_b", 32'(busy_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_dump(1'b0, 0, 65, 1'b0);
    run_dump(1'b1, 1, 63, 1'b0);
    run_dump(1'b0, 0, 74, 1'b1);
    regs[20] = 32'h114;

    // start together with abort in IDLE stays in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_output("start_abort_busy", 32'(busy), 32'd0);

    // Abort while word 10 is on the output.
    found = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_idx == 5'd10) found = 1'b1;
    end
    check_output("abort_reached_idx10", 32'(found), 32'd1);
    check_output("abort_pre_data", out_data, 32'h10A);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_out_valid", 32'(out_valid), 32'd0);
    check_output("abort_out_data", out_data, 32'd0);
    check_output("abort_out_idx", 32'(out_idx), 32'd0);
    seen_done = done;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check_output("abort_no_done", 32'(seen_done), 32'd0);

    // Asynchronous reset while requesting idx 4.
    found = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rf_req && rf_addr == 5'd4) found = 1'b1;
    end
    check_output("reset_reached_req4", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_busy", 32'(busy), 32'd0);
    check_output("async_rf_req", 32'(rf_req), 32'd0);
    check_output("async_rf_addr", 32'(rf_addr), 32'd0);
    check_output("async_out_idx", 32'(out_idx), 32'd0);
    check_output("async_out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_dump(1'b0, 0, 65, 1'b0);
  endtask

  initial begin
    apply_stimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
